// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- instruction fetch stage feeding the decode stage.
//
// Owns the program counter and issues word-aligned fetch requests to the
// instruction memory over a valid/ready handshake. Each issued request takes
// a slot in a small in-order queue. The slot is filled when its response
// returns. The oldest filled slot is presented to decode as {pc, instr}.
// A redirect flushes the queue and restarts fetch at a new PC. Responses
// that are still in flight at that moment are counted in `drop` and
// discarded when they arrive.
//
// Parameters:
//   RESET_PC  first PC fetched after reset (word aligned)
//   DEPTH     queue slots (power of two, 2..8); bounds the number of
//             outstanding plus buffered fetches
//
// Ports:
//   i_clk             clock, all state changes on the rising edge
//   i_rst_n           synchronous active-low reset
//   o_imem_req_valid  fetch request valid
//   i_imem_req_ready  memory accepts the request this cycle
//   o_imem_req_addr   fetch address (current PC)
//   i_imem_rsp_valid  in-order response valid, always accepted
//   i_imem_rsp_data   fetched instruction word
//   i_redirect        flush and restart fetch at i_redirect_pc
//   i_redirect_pc     new PC, bits [1:0] ignored
//   o_if_valid        head entry valid toward decode
//   i_if_ready        decode accepts the head entry
//   o_if_pc           PC of the head entry
//   o_if_instr        instruction of the head entry
// ---------------------------------------------------------------------------
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_if_valid,
    input  logic        i_if_ready,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Control state
    logic [31:0]      pc;
    logic [DEPTH-1:0] q_filled;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    fill_ptr;
    logic [CW-1:0]    used;      // allocated slots, filled or not
    logic [CW-1:0]    unfilled;  // allocated slots still waiting for data
    logic [CW-1:0]    drop;      // stale responses still to be discarded

    // Data storage (not reset; only read when the slot is marked filled)
    logic [31:0] q_pc    [DEPTH];
    logic [31:0] q_instr [DEPTH];

    logic          req_valid;
    logic          if_valid;
    logic          do_pop;
    logic          do_alloc;
    logic          rsp_fill;
    logic          rsp_drop;
    logic [CW:0]   budget;
    logic [CW-1:0] inflight;
    logic [CW-1:0] redirect_drop;
    logic          unused_pc_bits;

    // Slots in use plus stale responses still owed. This uses the occupancy
    // before any pop, so i_if_ready has no path to o_imem_req_valid.
    assign budget    = {1'b0, used} + {1'b0, drop};
    assign req_valid = i_rst_n && !i_redirect && (budget < {1'b0, DEPTH_C});
    assign do_alloc  = req_valid && i_imem_req_ready;

    assign if_valid  = i_rst_n && q_filled[head];
    assign do_pop    = if_valid && i_if_ready;

    // While stale responses are owed they are consumed first. A response
    // with nothing outstanding is a protocol error and is ignored.
    assign rsp_drop  = i_imem_rsp_valid && (drop != '0);
    assign rsp_fill  = i_imem_rsp_valid && (drop == '0) && (unfilled != '0);

    // On a redirect, every request still in flight becomes a stale response.
    // A response arriving in the same cycle has already come back, so it
    // is not counted.
    assign inflight      = drop + unfilled;
    assign redirect_drop = inflight - CW'(i_imem_rsp_valid && (inflight != '0));

    assign unused_pc_bits = ^i_redirect_pc[1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc       <= RESET_PC;
            q_filled <= '0;
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            used     <= '0;
            unfilled <= '0;
            drop     <= '0;
        end else if (i_redirect) begin
            // A redirect overrides any pop, fill or allocation in the same cycle
            pc       <= {i_redirect_pc[31:2], 2'b00};
            q_filled <= '0;
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            used     <= '0;
            unfilled <= '0;
            drop     <= redirect_drop;
        end else begin
            // Pop, allocate and fill always touch different slots. The head
            // is filled, the fill target is unfilled, and an allocation
            // needs a free slot.
            if (do_pop) begin
                q_filled[head] <= 1'b0;
                head           <= head + PW'(1);
            end
            if (do_alloc) begin
                tail <= tail + PW'(1);
                pc   <= pc + 32'd4;
            end
            if (rsp_fill) begin
                q_filled[fill_ptr] <= 1'b1;
                fill_ptr           <= fill_ptr + PW'(1);
            end
            if (rsp_drop) begin
                drop <= drop - CW'(1);
            end
            used     <= used + CW'(do_alloc) - CW'(do_pop);
            unfilled <= unfilled + CW'(do_alloc) - CW'(rsp_fill);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_alloc) begin
            q_pc[tail] <= pc;
        end
        if (rsp_fill) begin
            q_instr[fill_ptr] <= i_imem_rsp_data;
        end
    end

    assign o_imem_req_valid = req_valid;
    assign o_imem_req_addr  = pc;
    assign o_if_valid       = if_valid;
    // Zero when the head is not valid, so the outputs read 0 after reset
    // even though the storage itself is not cleared.
    assign o_if_pc          = if_valid ? q_pc[head]    : 32'h0;
    assign o_if_instr       = if_valid ? q_instr[head] : 32'h0;

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    ifetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_req_addr  (req_addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .o_if_valid       (if_valid),
        .i_if_ready       (if_ready),
        .o_if_pc          (if_pc),
        .o_if_instr       (if_instr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: the fetch queue as a list of {pc, instr, filled}
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          filled;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] mpc;
    int          mdrop;
    bit          known = 0;
    int          pops = 0;

    // Memory model: pending requests with the cycle they may respond
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t mem_q[$];
    int    lat = 1;
    int    last_due = 0;
    bit    rsp_rand = 0;

    // DUT outputs sampled in the last step
    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit rn, input bit rr, input bit ir, input bit rd,
                        input logic [31:0] rpc);
        bit e_rv, e_iv, found;
        int due, outst;
        @(negedge clk);
        rst_n = rn; req_ready = rr; if_ready = ir; redirect = rd; redirect_pc = rpc;
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
        if (rn && mem_q.size() > 0 && mem_q[0].due <= cyc &&
            (!rsp_rand || $urandom_range(0, 3) != 0)) begin
            rsp_valid = 1'b1;
            rsp_data  = instr_of(mem_q[0].addr);
        end
        #1;
        s_rv = req_valid; s_addr = req_addr; s_iv = if_valid; s_pc = if_pc; s_instr = if_instr;

        e_rv = rn && !rd && (mq.size() + mdrop < DEPTH);
        e_iv = rn && mq.size() > 0 && mq[0].filled;
        if (known) begin
            chk("m_req_valid", {31'h0, s_rv}, {31'h0, e_rv});
            if (e_rv) chk("m_req_addr", s_addr, mpc);
            chk("m_if_valid", {31'h0, s_iv}, {31'h0, e_iv});
            if (e_iv) begin
                chk("m_if_pc", s_pc, mq[0].pc);
                chk("m_if_instr", s_instr, mq[0].instr);
            end
        end

        // Memory reacts to the real bus
        if (!rn) begin
            mem_q.delete();
            last_due = 0;
        end else begin
            if (rsp_valid) void'(mem_q.pop_front());
            if (s_rv && rr) begin
                due = cyc + lat;
                if (due < last_due) due = last_due;
                last_due = due;
                mem_q.push_back('{s_addr, due});
            end
        end

        // Model update at the edge
        if (!rn) begin
            mq.delete();
            mpc = RPC;
            mdrop = 0;
            known = 1;
        end else if (known) begin
            if (rd) begin
                outst = mdrop;
                foreach (mq[i]) if (!mq[i].filled) outst++;
                if (rsp_valid && outst > 0) outst--;
                mdrop = outst;
                mq.delete();
                mpc = {rpc[31:2], 2'b00};
            end else begin
                if (e_iv && ir) begin
                    void'(mq.pop_front());
                    pops++;
                end
                if (rsp_valid) begin
                    if (mdrop > 0) mdrop--;
                    else begin
                        found = 0;
                        for (int i = 0; i < mq.size(); i++) begin
                            if (!mq[i].filled) begin
                                mq[i].filled = 1;
                                mq[i].instr  = instr_of(mq[i].pc);
                                found = 1;
                                break;
                            end
                        end
                        if (!found) begin
                            checks++;
                            errors++;
                            $display("FAIL protocol cyc=%0d response with no outstanding request", cyc);
                        end
                    end
                end
                if (e_rv && rr) begin
                    mq.push_back('{mpc, 32'h0, 1'b0});
                    mpc = mpc + 32'd4;
                end
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    typedef struct {
        bit          rn, rr, ir;
        bit          rv;
        logic [31:0] addr;
        bit          iv;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(input bit rn, input bit rr, input bit ir, input bit rv,
                                input logic [31:0] addr, input bit iv, input logic [31:0] pc);
        vec_t v;
        v.rn = rn; v.rr = rr; v.ir = ir; v.rv = rv; v.addr = addr; v.iv = iv; v.pc = pc;
        return v;
    endfunction

    initial begin
        vec_t vt[18];
        bit   seen;
        bit   rn, rr, ir, rd;
        logic [31:0] rpc;

        // Reset, streaming with 1-cycle memory, then back-pressure and release
        vt[0]  = mk(0, 1, 1, 0, 32'h0,   0, 32'h0);
        vt[1]  = mk(0, 1, 1, 0, 32'h0,   0, 32'h0);
        vt[2]  = mk(1, 1, 1, 1, 32'h100, 0, 32'h0);
        vt[3]  = mk(1, 1, 1, 1, 32'h104, 0, 32'h0);
        vt[4]  = mk(1, 1, 1, 0, 32'h0,   1, 32'h100);
        vt[5]  = mk(1, 1, 1, 1, 32'h108, 1, 32'h104);
        vt[6]  = mk(1, 1, 1, 1, 32'h10C, 0, 32'h0);
        vt[7]  = mk(1, 1, 1, 0, 32'h0,   1, 32'h108);
        vt[8]  = mk(1, 1, 1, 1, 32'h110, 1, 32'h10C);
        vt[9]  = mk(0, 1, 1, 0, 32'h0,   0, 32'h0);
        vt[10] = mk(1, 1, 0, 1, 32'h100, 0, 32'h0);
        vt[11] = mk(1, 1, 0, 1, 32'h104, 0, 32'h0);
        vt[12] = mk(1, 1, 0, 0, 32'h0,   1, 32'h100);
        vt[13] = mk(1, 1, 0, 0, 32'h0,   1, 32'h100);
        vt[14] = mk(1, 1, 0, 0, 32'h0,   1, 32'h100);
        vt[15] = mk(1, 1, 1, 0, 32'h0,   1, 32'h100);
        vt[16] = mk(1, 1, 1, 1, 32'h108, 1, 32'h104);
        vt[17] = mk(1, 1, 1, 1, 32'h10C, 0, 32'h0);

        lat = 1;
        rsp_rand = 0;
        for (int i = 0; i < 18; i++) begin
            step(vt[i].rn, vt[i].rr, vt[i].ir, 1'b0, 32'h0);
            chk("tbl_req_valid", {31'h0, s_rv}, {31'h0, vt[i].rv});
            if (vt[i].rv) chk("tbl_req_addr", s_addr, vt[i].addr);
            chk("tbl_if_valid", {31'h0, s_iv}, {31'h0, vt[i].iv});
            if (vt[i].iv) begin
                chk("tbl_if_pc", s_pc, vt[i].pc);
                chk("tbl_if_instr", s_instr, instr_of(vt[i].pc));
            end
        end

        // 3-cycle memory, two outstanding, redirect to an unaligned PC
        lat = 3;
        step(0, 1, 1, 0, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        chk("redir_addr0", s_addr, 32'h100);
        step(1, 1, 1, 0, 32'h0);
        chk("redir_addr1", s_addr, 32'h104);
        step(1, 1, 1, 1, 32'h2003);
        chk("redir_no_req", {31'h0, s_rv}, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        chk("redir_drop_full", {31'h0, s_rv}, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        chk("redir_req_valid", {31'h0, s_rv}, 32'h1);
        chk("redir_new_addr", s_addr, 32'h2000);
        chk("redir_no_stale", {31'h0, s_iv}, 32'h0);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step(1, 1, 1, 0, 32'h0);
            if (s_iv) seen = 1;
        end
        chk("redir_first_pc", s_pc, 32'h2000);

        // Redirect coinciding with a response, a pop and req_ready
        lat = 1;
        step(0, 1, 1, 0, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        step(1, 1, 1, 1, 32'h3000);
        chk("coinc_no_req", {31'h0, s_rv}, 32'h0);
        chk("coinc_pop_valid", {31'h0, s_iv}, 32'h1);
        step(1, 1, 1, 0, 32'h0);
        chk("coinc_addr", s_addr, 32'h3000);
        chk("coinc_no_stale", {31'h0, s_iv}, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        chk("coinc_first_pc", s_pc, 32'h3000);

        // PC wrap at the top of the address space
        step(0, 1, 1, 0, 32'h0);
        step(1, 1, 1, 1, 32'hFFFF_FFFE);
        step(1, 1, 1, 0, 32'h0);
        chk("wrap_top", s_addr, 32'hFFFF_FFFC);
        step(1, 1, 1, 0, 32'h0);
        chk("wrap_zero_valid", {31'h0, s_rv}, 32'h1);
        chk("wrap_zero", s_addr, 32'h0);

        // One-cycle reset with the queue full
        step(0, 1, 0, 0, 32'h0);
        for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 32'h0);
        chk("full_valid", {31'h0, s_iv}, 32'h1);
        chk("full_no_req", {31'h0, s_rv}, 32'h0);
        step(0, 1, 1, 0, 32'h0);
        chk("rst_req_valid", {31'h0, s_rv}, 32'h0);
        chk("rst_if_valid", {31'h0, s_iv}, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        chk("rst_first_addr", s_addr, RPC);
        chk("rst_if_valid_after", {31'h0, s_iv}, 32'h0);

        // Randomized traffic against the model
        rsp_rand = 1;
        pops = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) lat = $urandom_range(1, 4);
            rn  = ($urandom_range(0, 299) != 0);
            rr  = ($urandom_range(0, 3) != 0);
            ir  = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            step(rn, rr, ir, rd, rpc);
        end
        chk("rand_progress", {31'h0, pops > 200}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
